// File: rtl/truth_table_probe_pkg.sv
// Shared types and helpers for the truth-table probe: FSM states, vector count
// and the row-to-bit mapping used by the Cello hex convention (row 000 is the MSB).
package truth_table_probe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_VECTORS = 8;
  localparam int VEC_W       = $clog2(NUM_VECTORS);

  function automatic logic [VEC_W-1:0] row_to_bit(input logic [VEC_W-1:0] i);
    return VEC_W'(NUM_VECTORS - 1) - i;
  endfunction

endpackage

// File: rtl/truth_table_probe_if.sv
// Sweep control, stimulus and result bundle between the probe (slave) and the
// bench/score side that owns start, expected and the DUT output (master).
interface truth_table_probe_if;
  import truth_table_probe_pkg::*;

  logic                   start;
  logic [NUM_VECTORS-1:0] expected;
  logic [VEC_W-1:0]       dut_in;
  logic                   dut_out;
  logic                   busy;
  logic                   done;
  logic [NUM_VECTORS-1:0] table_out;
  logic                   match;
  logic                   unstable;

  modport master (
    output start, expected, dut_out,
    input  dut_in, busy, done, table_out, match, unstable
  );

  modport slave (
    input  start, expected, dut_out,
    output dut_in, busy, done, table_out, match, unstable
  );

endinterface

// File: rtl/truth_table_probe_settle_timer.sv
// Per-vector settle counter: tc marks the final-sample edge, win marks the
// STABLE_WIN-1 edges just before it for the optional stability check.
module truth_table_probe_settle_timer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int STABLE_WIN    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc,
  output logic win
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

  assign tc  = en && (cnt == LAST);
  // Integer compare keeps the window bound signed so STABLE_WIN == SETTLE_CYCLES works.
  assign win = en && (int'(cnt) >= SETTLE_CYCLES - STABLE_WIN) && (cnt != LAST);

endmodule

// File: rtl/truth_table_probe.sv
// Sweeps all 8 rows of a 3-input DUT, assembles the truth table and compares it
// with a captured reference. Optional macro: TRUTH_TABLE_PROBE_STABILITY_CHECK_EN.
module truth_table_probe
  import truth_table_probe_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int STABLE_WIN    = 2
) (
  input logic                 clk,
  input logic                 rst,
  truth_table_probe_if.slave  probe
);

  state_t                 state_q;
  logic [VEC_W-1:0]       vec_q;
  logic                   busy_q;
  logic                   done_q;
  logic [NUM_VECTORS-1:0] table_out_q;
  logic                   match_q;
  logic [NUM_VECTORS-1:0] tbl_q;
  logic [NUM_VECTORS-1:0] tbl_nxt;
  logic [NUM_VECTORS-1:0] expected_q;
  logic                   accept;
  logic                   tc;
  logic                   win;

  assign accept = probe.start && (state_q != RUN);

  truth_table_probe_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .STABLE_WIN    (STABLE_WIN)
  ) u_settle_timer (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (state_q == RUN),
    .tc  (tc),
    .win (win)
  );

  always_comb begin
    tbl_nxt = tbl_q;
    tbl_nxt[row_to_bit(vec_q)] = probe.dut_out;
  end

  // Data registers: every bit is rewritten during a sweep, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      expected_q <= probe.expected;
    end
    if (tc) begin
      tbl_q <= tbl_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      table_out_q <= '0;
      match_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (probe.start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            vec_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (tc) begin
            if (vec_q == VEC_W'(NUM_VECTORS - 1)) begin
              state_q     <= DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              vec_q       <= '0;
              table_out_q <= tbl_nxt;
              match_q     <= (tbl_nxt == expected_q);
            end else begin
              vec_q <= vec_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          vec_q   <= '0;
        end
      endcase
    end
  end

  assign probe.dut_in    = vec_q;
  assign probe.busy      = busy_q;
  assign probe.done      = done_q;
  assign probe.table_out = table_out_q;
  assign probe.match     = match_q;

`ifdef TRUTH_TABLE_PROBE_STABILITY_CHECK_EN
  logic seen0_q;
  logic seen1_q;
  logic unstable_q;

  // Window samples record which levels were seen; the final sample must agree with all of them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen0_q    <= 1'b0;
      seen1_q    <= 1'b0;
      unstable_q <= 1'b0;
    end else if (accept) begin
      seen0_q    <= 1'b0;
      seen1_q    <= 1'b0;
      unstable_q <= 1'b0;
    end else if (tc) begin
      if ((seen0_q && probe.dut_out) || (seen1_q && !probe.dut_out)) begin
        unstable_q <= 1'b1;
      end
      seen0_q <= 1'b0;
      seen1_q <= 1'b0;
    end else if (win) begin
      seen0_q <= seen0_q | ~probe.dut_out;
      seen1_q <= seen1_q | probe.dut_out;
    end
  end

  assign probe.unstable = unstable_q;
`else
  logic unused_win;
  assign unused_win     = win;
  assign probe.unstable = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_probe.sv
// Directed bench for truth_table_probe: S=4 instance for the main scenarios,
// S=1 instance for back-to-back sweeps with start held high.
module tb_truth_table_probe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  int   t0     = 0;
  int   sel4   = 0;
  logic glitch_en = 1'b0;

  truth_table_probe_if pif4 ();
  truth_table_probe_if pif1 ();

  truth_table_probe #(.SETTLE_CYCLES(4), .STABLE_WIN(2)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .probe (pif4)
  );

  truth_table_probe #(.SETTLE_CYCLES(1), .STABLE_WIN(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .probe (pif1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic model(input int sel, input logic [2:0] v);
    logic in1, in2, in3;
    in1 = v[2]; in2 = v[1]; in3 = v[0];
    case (sel)
      0:       return (in2 & ~in1) | (~in2 & ~(in3 & ~in1));
      1:       return in1;
      2:       return in3;
      default: return 1'b0;
    endcase
  endfunction

  // Glitch flips the output for the cycle ending at the final sample of vector 5.
  assign pif4.dut_out = model(sel4, pif4.dut_in) ^ (glitch_en && (cyc - t0 == 23));
  assign pif1.dut_out = model(0, pif1.dut_in);

  task automatic start4(input logic [7:0] exp);
    pif4.start    = 1'b1;
    pif4.expected = exp;
    @(posedge clk); #1;
    pif4.start    = 1'b0;
    t0            = cyc;
  endtask

  task automatic wait_done4(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (pif4.done !== 1'b1 && n < 200);
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({pif4.busy, pif4.done, pif4.match, pif4.unstable} !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", {pif4.busy, pif4.done, pif4.match, pif4.unstable});
    else passed++;
    total++;
    if ({pif4.table_out, pif4.dut_in} !== 11'h000) $display("FAIL reset_data: got table=%h dut_in=%0d want 00/0", pif4.table_out, pif4.dut_in);
    else passed++;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    int n;
    start4(8'hBC);
    total++;
    if (pif4.busy !== 1'b1 || pif4.dut_in !== 3'd0) $display("FAIL nominal_start: got busy=%b dut_in=%0d want 1/0", pif4.busy, pif4.dut_in);
    else passed++;
    wait_done4(n);
    total++;
    if (n !== 32) $display("FAIL nominal_latency: got %0d want 32", n);
    else passed++;
    total++;
    if (pif4.table_out !== 8'hBC || pif4.match !== 1'b1 || pif4.busy !== 1'b0) $display("FAIL nominal_result: got table=%h match=%b busy=%b want bc/1/0", pif4.table_out, pif4.match, pif4.busy);
    else passed++;
    total++;
    if (pif4.unstable !== 1'b0) $display("FAIL nominal_unstable: got %b want 0", pif4.unstable);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (pif4.done !== 1'b0 || pif4.table_out !== 8'hBC || pif4.match !== 1'b1) $display("FAIL done_pulse: got done=%b table=%h match=%b want 0/bc/1", pif4.done, pif4.table_out, pif4.match);
    else passed++;
  endtask

  task automatic test_mismatch();
    int n;
    start4(8'hBD);
    wait_done4(n);
    total++;
    if (pif4.table_out !== 8'hBC || pif4.match !== 1'b0) $display("FAIL mismatch: got table=%h match=%b want bc/0", pif4.table_out, pif4.match);
    else passed++;
  endtask

  task automatic test_row_order();
    int n;
    sel4 = 1;
    start4(8'h0F);
    wait_done4(n);
    total++;
    if (pif4.table_out !== 8'h0F || pif4.match !== 1'b1) $display("FAIL row_in1: got table=%h match=%b want 0f/1", pif4.table_out, pif4.match);
    else passed++;
    sel4 = 2;
    start4(8'h55);
    wait_done4(n);
    total++;
    if (pif4.table_out !== 8'h55 || pif4.match !== 1'b1) $display("FAIL row_in3: got table=%h match=%b want 55/1", pif4.table_out, pif4.match);
    else passed++;
    sel4 = 0;
  endtask

  task automatic test_start_busy();
    int n;
    start4(8'hBC);
    repeat (13) @(posedge clk);
    #1;
    total++;
    if (pif4.dut_in !== 3'd3) $display("FAIL busy_vec: got %0d want 3", pif4.dut_in);
    else passed++;
    pif4.start    = 1'b1;
    pif4.expected = 8'h00;
    @(posedge clk); #1;
    pif4.start    = 1'b0;
    pif4.expected = 8'hFF;
    wait_done4(n);
    total++;
    if (n + 14 !== 32) $display("FAIL busy_latency: got %0d want 32", n + 14);
    else passed++;
    total++;
    if (pif4.table_out !== 8'hBC || pif4.match !== 1'b1) $display("FAIL busy_result: got table=%h match=%b want bc/1", pif4.table_out, pif4.match);
    else passed++;
  endtask

  task automatic test_reset_abort();
    int n;
    int dones;
    start4(8'hBC);
    repeat (21) @(posedge clk);
    #3;
    total++;
    if (pif4.busy !== 1'b1 || pif4.dut_in !== 3'd5) $display("FAIL abort_pre: got busy=%b dut_in=%0d want 1/5", pif4.busy, pif4.dut_in);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if ({pif4.busy, pif4.done, pif4.match, pif4.unstable, pif4.table_out, pif4.dut_in} !== 15'h0) $display("FAIL abort_reset: got busy=%b done=%b match=%b table=%h dut_in=%0d want all 0", pif4.busy, pif4.done, pif4.match, pif4.table_out, pif4.dut_in);
    else passed++;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (pif4.done === 1'b1 || pif4.busy === 1'b1) dones++;
    end
    total++;
    if (dones !== 0) $display("FAIL abort_quiet: got %0d active cycles want 0", dones);
    else passed++;
    start4(8'hBC);
    wait_done4(n);
    total++;
    if (n !== 32 || pif4.table_out !== 8'hBC || pif4.match !== 1'b1) $display("FAIL abort_restart: got n=%0d table=%h match=%b want 32/bc/1", n, pif4.table_out, pif4.match);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int d [3];
    int nd;
    d  = '{-1, -1, -1};
    nd = 0;
    pif1.start    = 1'b1;
    pif1.expected = 8'hBC;
    @(posedge clk); #1;
    for (int k = 1; k <= 40 && nd < 3; k++) begin
      @(posedge clk); #1;
      if (pif1.done === 1'b1) begin
        d[nd] = k;
        nd++;
        total++;
        if (pif1.table_out !== 8'hBC || pif1.match !== 1'b1) $display("FAIL b2b_table%0d: got table=%h match=%b want bc/1", nd, pif1.table_out, pif1.match);
        else passed++;
      end
    end
    pif1.start = 1'b0;
    total++;
    if (d[0] !== 8 || d[1] !== 17 || d[2] !== 26) $display("FAIL b2b_timing: got %0d,%0d,%0d want 8,17,26", d[0], d[1], d[2]);
    else passed++;
  endtask

  task automatic test_stability();
    int   n;
    logic exp_unstable;
`ifdef TRUTH_TABLE_PROBE_STABILITY_CHECK_EN
    exp_unstable = 1'b1;
`else
    exp_unstable = 1'b0;
`endif
    sel4      = 1;
    glitch_en = 1'b1;
    start4(8'h0F);
    wait_done4(n);
    glitch_en = 1'b0;
    total++;
    if (pif4.table_out !== 8'h0B || pif4.match !== 1'b0) $display("FAIL stab_table: got table=%h match=%b want 0b/0", pif4.table_out, pif4.match);
    else passed++;
    total++;
    if (pif4.unstable !== exp_unstable) $display("FAIL stab_flag: got %b want %b", pif4.unstable, exp_unstable);
    else passed++;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (pif4.unstable !== exp_unstable) $display("FAIL stab_hold: got %b want %b", pif4.unstable, exp_unstable);
    else passed++;
    sel4 = 0;
    start4(8'hBC);
    total++;
    if (pif4.unstable !== 1'b0) $display("FAIL stab_clear: got %b want 0", pif4.unstable);
    else passed++;
    wait_done4(n);
    total++;
    if (pif4.unstable !== 1'b0 || pif4.table_out !== 8'hBC) $display("FAIL stab_clean: got unstable=%b table=%h want 0/bc", pif4.unstable, pif4.table_out);
    else passed++;
  endtask

  initial begin
    pif4.start    = 1'b0;
    pif4.expected = 8'h00;
    pif1.start    = 1'b0;
    pif1.expected = 8'h00;
    test_reset();
    test_nominal();
    test_mismatch();
    test_row_order();
    test_start_busy();
    test_reset_abort();
    test_back_to_back();
    test_stability();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/truth_table_probe.md
# truth_table_probe

Sequential characterisation engine for 3-input combinational logic circuits such as the gate-level netlists produced by the Cello flow. It drives all 8 input combinations into a device under test (DUT) and waits a programmable settle time per vector. It samples the DUT output, assembles the measured 8-bit truth table in Cello hex convention (for example 0xBC) and compares it with an expected value. It sits on the bench/score side of the design, at the read end of each synthesised logic block.

## Interface
- SETTLE_CYCLES, 4: cycles each vector is held before `dut_out` is sampled; legal range ≥1.
- STABLE_WIN, 2: stability window length in cycles; only used with the macro; legal range 1..SETTLE_CYCLES.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a sweep; accepted only when busy=0.
- expected  in  8  reference truth table; captured on accepted start.
- dut_in  out  3  DUT stimulus; bit 2 = in1, bit 1 = in2, bit 0 = in3.
- dut_out  in  1  DUT output; synchronous to clk, combinational from dut_in.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep completion.
- table_out  out  8  measured truth table; held until the next completion.
- match  out  1  table_out == captured expected; valid from done onward.
- unstable  out  1  stability violation seen in the last sweep (macro only).

## Operation
- Row index i = {in1,in2,in3} = dut_in. Result bit table[7-i] = dut_out at row i, so row 000 is the MSB.
- FSM states:
  - IDLE: busy=0, dut_in=0. start=1 goes to RUN.
  - RUN: vector counter vec runs 0..7, settle counter cnt runs 0..SETTLE_CYCLES-1.
    - When cnt==SETTLE_CYCLES-1: sample dut_out into the shift/table register, clear cnt, increment vec.
    - When the sample is for vec==7: go to DONE.
  - DONE: lasts one cycle. done=1, busy=0, then return to IDLE.
- On entering DONE: table_out is loaded and match = (table == expected_q), both in the same cycle.
- start while busy=1 is ignored. start during the DONE cycle is accepted, because busy=0 there.
- expected is registered at start acceptance. Later changes to it have no effect on the running sweep.
- Counter widths: vec is 3 bits with no wrap beyond 7. cnt is $clog2(SETTLE_CYCLES+1) bits.
- Reset values (asynchronous): state=IDLE, dut_in=0, busy=0, done=0, table_out=0, match=0, unstable=0.
- Reset mid-sweep aborts immediately. No done pulse is produced and the partial table is discarded.

## Timing
- Edge E0 accepts start. After E0: busy=1, dut_in=0.
- Vector i is driven from edge E0+i·S to E0+(i+1)·S, where S=SETTLE_CYCLES.
- dut_out for vector i is sampled at edge E0+(i+1)·S.
- After edge E0+8·S: done=1 for one cycle, busy=0, table_out and match valid.
- Latency from start edge to done is 8·S cycles. The next sweep may start on the done cycle.

## Configuration
- Macro: TRUTH_TABLE_PROBE_STABILITY_CHECK_EN.
- With the macro defined:
  - dut_out is also sampled on the STABLE_WIN−1 edges that precede the final sample of each vector.
  - Any mismatch with the final sample sets unstable.
  - unstable is sticky for the sweep, cleared on start acceptance, and held after done.
- Without the macro: no window logic is built and unstable is tied to 0.

## Structure
- Package truth_table_probe_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - NUM_VECTORS=8;
  - a function row_to_bit(i) that returns 7-i.
- One sub-module, truth_table_probe_settle_timer. It is the parameterised cnt counter, with a terminal-count output and a window-active output for the stability check.
- The FSM, vector counter and table register stay in the top level.

## Test plan
- **Nominal 0xBC pass:** bench DUT implements `out = (in2&~in1) | (~in2&~(in3&~in1))`; S=4, expected=8'hBC, start. Required: done exactly 32 cycles after the start edge, table_out=8'hBC, match=1.
- **Mismatch:** same DUT with expected=8'hBD. Required: table_out=8'hBC, match=0.
- **Row ordering:** DUT out=in1. Required: table_out=8'h0F. DUT out=in3. Required: table_out=8'h55.
- **Start during busy and reset abort:**
  - start pulsed at vec=3 is ignored, and completion timing is unchanged.
  - rst asserted at vec=5 gives all outputs at reset values immediately and no done.
  - A fresh start then completes normally.
- **Back-to-back sweeps:** S=1, start held high. Required: done every 9 cycles after the first, which comes at 8 cycles, with a correct table on each sweep.
- **Stability check:** macro on, S=4, STABLE_WIN=2, bench DUT toggles output one cycle before the final sample of vector 5. Required: unstable=1 at done. Macro off, same stimulus: unstable=0.
